// File: rtl/itcm_pkg.sv
// Shared types and default geometry for the ITCM arbiter slice.
package itcm_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_e;

  localparam int          ITCM_AW         = 14;
  localparam logic [31:0] ITCM_BASE       = 32'h0000_0000;
  localparam int          ITCM_STARVE_MAX = 4;

  // rd marks a response that carries memory data back to the owner.
  typedef struct packed {
    owner_e own;
    logic   err;
    logic   rd;
  } rsp_t;

endpackage

// File: rtl/itcm_addr_chk.sv
// Byte address -> ITCM word address plus window hit; offset arithmetic wraps at 32 bits.
module itcm_addr_chk #(
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter int          AW   = 14
) (
  input  logic [31:0]   addr_i,
  output logic          in_range_o,
  output logic [AW-1:0] word_addr_o
);

  logic [31:0] off;

  assign off = addr_i - BASE;
  // 33-bit compare so the window size cannot overflow for large AW.
  assign in_range_o  = {1'b0, off} < (33'd4 << AW);
  assign word_addr_o = off[AW+1:2];

endmodule

// File: rtl/itcm_arbiter.sv
// Single-port ITCM shared by fetch (read-only) and loader (read/write); loader has
// priority unless fetch has been starved STARVE_MAX cycles. One-cycle response path.
module itcm_arbiter
  import itcm_pkg::*;
#(
  parameter int          AW         = ITCM_AW,
  parameter logic [31:0] BASE       = ITCM_BASE,
  parameter int          STARVE_MAX = ITCM_STARVE_MAX
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          f_req_i,
  input  logic [31:0]   f_addr_i,
  output logic          f_gnt_o,
  output logic          f_rvalid_o,
  output logic [31:0]   f_rdata_o,
  output logic          f_err_o,
  input  logic          l_req_i,
  input  logic          l_we_i,
  input  logic [3:0]    l_be_i,
  input  logic [31:0]   l_addr_i,
  input  logic [31:0]   l_wdata_i,
  output logic          l_gnt_o,
  output logic          l_rvalid_o,
  output logic [31:0]   l_rdata_o,
  output logic          l_err_o,
  output logic          m_en_o,
  output logic [3:0]    m_we_o,
  output logic [AW-1:0] m_addr_o,
  output logic [31:0]   m_wdata_o,
  input  logic [31:0]   m_rdata_i
);

  localparam int            SW   = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;
  rsp_t          rsp_q, rsp_d;
  logic          f_in, l_in, f_ok, f_force;
  logic [AW-1:0] f_word, l_word;

  itcm_addr_chk #(.BASE(BASE), .AW(AW)) u_chk_f (
    .addr_i(f_addr_i), .in_range_o(f_in), .word_addr_o(f_word)
  );

  itcm_addr_chk #(.BASE(BASE), .AW(AW)) u_chk_l (
    .addr_i(l_addr_i), .in_range_o(l_in), .word_addr_o(l_word)
  );

  assign f_ok    = f_in && (f_addr_i[1:0] == 2'b00);
  assign f_force = f_req_i && (starve_q == SMAX);

  // Grants are held low while in reset even if requests are already up.
  always_comb begin
    l_gnt_o   = rst_ni && l_req_i && !f_force;
    f_gnt_o   = rst_ni && f_req_i && !l_gnt_o;
    m_en_o    = 1'b0;
    m_we_o    = '0;
    m_addr_o  = '0;
    m_wdata_o = l_wdata_i;
    if (f_gnt_o && f_ok) begin
      m_en_o   = 1'b1;
      m_addr_o = f_word;
    end else if (l_gnt_o && l_in) begin
      m_en_o   = 1'b1;
      m_addr_o = l_word;
      m_we_o   = l_we_i ? l_be_i : 4'b0000;
    end
  end

  always_comb begin
    starve_d = '0;
    if (f_req_i && !f_gnt_o)
      starve_d = (starve_q == SMAX) ? starve_q : starve_q + 1'b1;
  end

  always_comb begin
    rsp_d     = '0;
    rsp_d.own = OWN_NONE;
    if (f_gnt_o) begin
      rsp_d.own = OWN_FETCH;
      rsp_d.err = !f_ok;
      rsp_d.rd  = f_ok;
    end else if (l_gnt_o) begin
      rsp_d.own = OWN_LOAD;
      rsp_d.err = !l_in;
      rsp_d.rd  = l_in && !l_we_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q  <= '0;
      rsp_q     <= '0;
      rsp_q.own <= OWN_NONE;
    end else begin
      starve_q  <= starve_d;
      rsp_q     <= rsp_d;
    end
  end

  assign f_rvalid_o = (rsp_q.own == OWN_FETCH);
  assign f_err_o    = f_rvalid_o && rsp_q.err;
  assign f_rdata_o  = (f_rvalid_o && rsp_q.rd) ? m_rdata_i : '0;
  assign l_rvalid_o = (rsp_q.own == OWN_LOAD);
  assign l_err_o    = l_rvalid_o && rsp_q.err;
  assign l_rdata_o  = (l_rvalid_o && rsp_q.rd) ? m_rdata_i : '0;

`ifndef SYNTHESIS
  a_f_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (f_req_i && !f_gnt_o) |=> (f_req_i && $stable(f_addr_i)));
  a_l_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (l_req_i && !l_gnt_o) |=> (l_req_i && $stable({l_we_i, l_be_i, l_addr_i, l_wdata_i})));
  a_one_gnt: assert property (@(posedge clk_i) !(f_gnt_o && l_gnt_o));
`endif

endmodule

// File: tb/tb_itcm_arbiter.sv
// Randomized and directed bench for itcm_arbiter against a transaction-level model.
module tb_itcm_arbiter;
  import itcm_pkg::*;

  localparam int          AW    = 14;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          SMAX  = 4;
  localparam int          DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          f_req = 1'b0;
  logic [31:0]   f_addr = '0;
  logic          l_req = 1'b0, l_we = 1'b0;
  logic [3:0]    l_be = '0;
  logic [31:0]   l_addr = '0, l_wdata = '0;
  logic          f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, l_err, m_en;
  logic [31:0]   f_rdata, l_rdata, m_wdata;
  logic [3:0]    m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_rdata = '0;

  itcm_arbiter #(.AW(AW), .BASE(BASE), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt), .f_rvalid_o(f_rvalid),
    .f_rdata_o(f_rdata), .f_err_o(f_err),
    .l_req_i(l_req), .l_we_i(l_we), .l_be_i(l_be), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
    .l_gnt_o(l_gnt), .l_rvalid_o(l_rvalid), .l_rdata_o(l_rdata), .l_err_o(l_err),
    .m_en_o(m_en), .m_we_o(m_we), .m_addr_o(m_addr), .m_wdata_o(m_wdata), .m_rdata_i(m_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'hDEAD_BEEF;
    if (i == 8) return 32'hFFFF_FFFF;
    return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0000;
  endfunction

  // ITCM macro: one-cycle read latency, byte-enabled writes.
  logic [31:0] ram [DEPTH];
  bit preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
    end else if (m_en) begin
      m_rdata <= ram[m_addr];
      for (int b = 0; b < 4; b++)
        if (m_we[b]) ram[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
    end
  end

  // Reference model: memory image, consecutive-denial count, one pending response.
  int            checks = 0, errors = 0;
  int            st;
  logic [31:0]   rmem [DEPTH];
  int            p_own;
  bit            p_err;
  logic [31:0]   p_data;
  bit            e_fg, e_lg, e_men;
  logic [3:0]    e_mwe;
  logic [AW-1:0] e_maddr;

  function automatic bit in_win(logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(4 * DEPTH);
  endfunction

  task automatic model_reset();
    st = 0; p_own = 0; p_err = 1'b0; p_data = '0;
  endtask

  task automatic model_eval();
    logic [31:0] off;
    e_lg = l_req && !(f_req && st == SMAX);
    e_fg = f_req && !e_lg;
    e_men = 1'b0; e_mwe = '0; e_maddr = '0;
    if (e_fg && in_win(f_addr) && (f_addr % 4 == 0)) begin
      off = f_addr - BASE;
      e_men = 1'b1; e_maddr = AW'(off >> 2);
    end
    if (e_lg && in_win(l_addr)) begin
      off = l_addr - BASE;
      e_men = 1'b1; e_maddr = AW'(off >> 2);
      if (l_we) e_mwe = l_be;
    end
  endtask

  task automatic model_commit();
    p_own = 0; p_err = 1'b0; p_data = '0;
    if (e_fg) begin
      p_own = 1;
      if (e_men) p_data = rmem[e_maddr]; else p_err = 1'b1;
    end else if (e_lg) begin
      p_own = 2;
      if (!e_men) p_err = 1'b1;
      else if (!l_we) p_data = rmem[e_maddr];
      else for (int b = 0; b < 4; b++)
        if (l_be[b]) rmem[e_maddr][8*b +: 8] = l_wdata[8*b +: 8];
    end
    st = (f_req && !e_fg) ? ((st + 1 > SMAX) ? SMAX : st + 1) : 0;
  endtask

  // Each cycle: inputs driven at posedge+1, sampled at posedge+4.
  task automatic settle();
    #3;
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit fg, lg;
    for (int n = 0; n < 8 && (f_req || l_req); n++) begin
      settle();
      fg = e_fg; lg = e_lg;
      advance();
      if (fg) f_req = 1'b0;
      if (lg) l_req = 1'b0;
    end
    checks++;
    if (f_req || l_req) begin errors++; $display("FAIL drain: requests still pending f=%b l=%b", f_req, l_req); end
  endtask

  function automatic logic [31:0] rand_addr(bit fetch);
    int r, w;
    r = $urandom_range(0, 19);
    w = $urandom_range(0, 63);
    if (r == 0) return 32'h0001_0000 + 32'($urandom_range(0, 255) * 4);
    if (r == 1) return 32'hFFFF_FFF0;
    if (r == 2 && fetch) return 32'(w * 4 + $urandom_range(1, 3));
    return 32'(w * 4 + (fetch ? 0 : $urandom_range(0, 3)));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; preload = 1'b1;
    f_req = 1'b1; l_req = 1'b1; l_we = 1'b1; l_be = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({f_gnt, l_gnt, m_en} !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", {f_gnt, l_gnt, m_en}); end
    checks++;
    if ({f_rvalid, l_rvalid, f_err, l_err, m_we} !== 8'h00) begin
      errors++; $display("FAIL reset_rsp: got %b want 0", {f_rvalid, l_rvalid, f_err, l_err, m_we});
    end
    checks++;
    if (f_rdata !== 32'h0 || l_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0", f_rdata, l_rdata); end
    f_req = 1'b0; l_req = 1'b0; l_we = 1'b0; l_be = '0; preload = 1'b0;
    for (int i = 0; i < DEPTH; i++) rmem[i] = init_word(i);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_read();
    f_req = 1'b1; f_addr = 32'h10;
    settle();
    checks++;
    if ({f_gnt, l_gnt, m_en} !== 3'b101 || m_addr !== 14'd4) begin
      errors++; $display("FAIL fetch_gnt: got gnt/en=%b addr=%0d want 101 addr=4", {f_gnt, l_gnt, m_en}, m_addr);
    end
    advance();
    f_req = 1'b0;
    settle();
    checks++;
    if ({f_rvalid, f_err, l_rvalid} !== 3'b100 || f_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL fetch_rsp: got v/e/lv=%b data=%h want 100 deadbeef", {f_rvalid, f_err, l_rvalid}, f_rdata);
    end
    advance();
  endtask

  task automatic test_loader_write();
    l_req = 1'b1; l_we = 1'b1; l_be = 4'b0011; l_addr = 32'h20; l_wdata = 32'h1234_ABCD;
    settle();
    checks++;
    if ({f_gnt, l_gnt, m_en} !== 3'b011 || m_we !== 4'b0011 || m_addr !== 14'd8) begin
      errors++; $display("FAIL lwr_gnt: got gnt/en=%b we=%b addr=%0d want 011 0011 8", {f_gnt, l_gnt, m_en}, m_we, m_addr);
    end
    advance();
    // Zero byte-enable write straight after: still a granted, enabled access.
    l_be = 4'b0000; l_wdata = 32'h0;
    settle();
    checks++;
    if ({l_rvalid, l_err} !== 2'b10 || l_rdata !== 32'h0 || ram[8] !== 32'hFFFF_ABCD) begin
      errors++; $display("FAIL lwr_rsp: got v/e=%b rdata=%h mem=%h want 10 0 ffffabcd", {l_rvalid, l_err}, l_rdata, ram[8]);
    end
    checks++;
    if ({l_gnt, m_en} !== 2'b11 || m_we !== 4'b0000) begin
      errors++; $display("FAIL lwr_be0: got gnt/en=%b we=%b want 11 0000", {l_gnt, m_en}, m_we);
    end
    advance();
    l_req = 1'b0; l_we = 1'b0;
    settle();
    checks++;
    if ({l_rvalid, l_err} !== 2'b10 || ram[8] !== 32'hFFFF_ABCD) begin
      errors++; $display("FAIL lwr_be0_rsp: got v/e=%b mem=%h want 10 ffffabcd", {l_rvalid, l_err}, ram[8]);
    end
    advance();
  endtask

  task automatic test_starve();
    f_req = 1'b1; f_addr = 32'h40; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h80;
    for (int i = 0; i < 10; i++) begin
      settle();
      checks++;
      if ({f_gnt, l_gnt} !== ((i % 5 == 4) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL starve_gnt[%0d]: got %b want %b", i, {f_gnt, l_gnt}, (i % 5 == 4) ? 2'b10 : 2'b01);
      end
      if (i > 0) begin
        checks++;
        if ({f_rvalid, l_rvalid} !== (((i - 1) % 5 == 4) ? 2'b10 : 2'b01) ||
            f_rdata !== ((p_own == 1) ? p_data : 32'h0) || l_rdata !== ((p_own == 2) ? p_data : 32'h0)) begin
          errors++; $display("FAIL starve_rsp[%0d]: got v=%b f=%h l=%h", i, {f_rvalid, l_rvalid}, f_rdata, l_rdata);
        end
      end
      advance();
    end
    drain();
  endtask

  task automatic test_errors();
    f_req = 1'b1; f_addr = 32'h0001_0000;
    settle();
    checks++;
    if ({f_gnt, m_en} !== 2'b10) begin errors++; $display("FAIL ferr_oor_gnt: got gnt/en=%b want 10", {f_gnt, m_en}); end
    advance();
    f_addr = 32'h2;
    settle();
    checks++;
    if ({f_rvalid, f_err} !== 2'b11 || f_rdata !== 32'h0 || {f_gnt, m_en} !== 2'b10) begin
      errors++; $display("FAIL ferr_oor_rsp: got v/e=%b data=%h gnt/en=%b want 11 0 10", {f_rvalid, f_err}, f_rdata, {f_gnt, m_en});
    end
    advance();
    f_req = 1'b0; l_req = 1'b1; l_we = 1'b0; l_addr = 32'hFFFF_FFF0;
    settle();
    checks++;
    if ({f_rvalid, f_err} !== 2'b11 || f_rdata !== 32'h0 || {l_gnt, m_en} !== 2'b10) begin
      errors++; $display("FAIL ferr_mis_rsp: got v/e=%b data=%h lgnt/en=%b want 11 0 10", {f_rvalid, f_err}, f_rdata, {l_gnt, m_en});
    end
    advance();
    l_req = 1'b0;
    settle();
    checks++;
    if ({l_rvalid, l_err} !== 2'b11 || l_rdata !== 32'h0) begin
      errors++; $display("FAIL lerr_rsp: got v/e=%b data=%h want 11 0", {l_rvalid, l_err}, l_rdata);
    end
    advance();
  endtask

  task automatic test_reset_pending();
    f_req = 1'b1; f_addr = 32'h18; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h1C;
    repeat (3) begin settle(); advance(); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({f_rvalid, l_rvalid, f_gnt, l_gnt, m_en} !== 5'b0 || l_rdata !== 32'h0) begin
      errors++; $display("FAIL rstp_out: got %b rdata=%h want 0", {f_rvalid, l_rvalid, f_gnt, l_gnt, m_en}, l_rdata);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      if (i == 0) begin
        checks++;
        if ({f_rvalid, l_rvalid} !== 2'b00) begin errors++; $display("FAIL rstp_drop: got %b want 00", {f_rvalid, l_rvalid}); end
      end
      checks++;
      if ({f_gnt, l_gnt} !== ((i == 4) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rstp_gnt[%0d]: got %b want %b", i, {f_gnt, l_gnt}, (i == 4) ? 2'b10 : 2'b01);
      end
      advance();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    f_req = 1'b1; f_addr = 32'h10;
    settle();
    checks++;
    if ({f_gnt, l_gnt} !== 2'b10) begin errors++; $display("FAIL b2b_g0: got %b want 10", {f_gnt, l_gnt}); end
    advance();
    f_req = 1'b0; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h20;
    settle();
    checks++;
    if ({f_gnt, l_gnt, f_rvalid, l_rvalid} !== 4'b0110 || f_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL b2b_c1: got %b data=%h want 0110 deadbeef", {f_gnt, l_gnt, f_rvalid, l_rvalid}, f_rdata);
    end
    advance();
    l_req = 1'b0; f_req = 1'b1; f_addr = 32'h14;
    settle();
    checks++;
    if ({f_gnt, l_gnt, f_rvalid, l_rvalid} !== 4'b1001 || l_rdata !== 32'hFFFF_ABCD) begin
      errors++; $display("FAIL b2b_c2: got %b data=%h want 1001 ffffabcd", {f_gnt, l_gnt, f_rvalid, l_rvalid}, l_rdata);
    end
    advance();
    f_req = 1'b0;
    settle();
    checks++;
    if ({f_rvalid, l_rvalid} !== 2'b10 || f_rdata !== init_word(5)) begin
      errors++; $display("FAIL b2b_c3: got %b data=%h want 10 %h", {f_rvalid, l_rvalid}, f_rdata, init_word(5));
    end
    advance();
  endtask

  task automatic test_random();
    bit f_done = 1'b0, l_done = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (!f_req || f_done) begin
        f_req = ($urandom_range(0, 3) != 0); f_addr = rand_addr(1'b1);
      end
      if (!l_req || l_done) begin
        l_req = ($urandom_range(0, 2) != 0); l_we = 1'($urandom_range(0, 1));
        l_be = 4'($urandom); l_wdata = $urandom; l_addr = rand_addr(1'b0);
      end
      settle();
      checks++;
      if ({f_gnt, l_gnt, m_en} !== {e_fg, e_lg, e_men}) begin
        errors++; $display("FAIL rnd_gnt[%0d]: got %b want %b", cyc, {f_gnt, l_gnt, m_en}, {e_fg, e_lg, e_men});
      end
      if (e_men) begin
        checks++;
        if (m_addr !== e_maddr || m_we !== e_mwe) begin
          errors++; $display("FAIL rnd_mem[%0d]: got addr=%0d we=%b want %0d %b", cyc, m_addr, m_we, e_maddr, e_mwe);
        end
      end
      checks++;
      if ({f_rvalid, f_err} !== {p_own == 1, p_own == 1 && p_err} || f_rdata !== ((p_own == 1) ? p_data : 32'h0)) begin
        errors++; $display("FAIL rnd_frsp[%0d]: got v/e=%b data=%h want %b %h", cyc, {f_rvalid, f_err}, f_rdata,
                           {p_own == 1, p_own == 1 && p_err}, (p_own == 1) ? p_data : 32'h0);
      end
      checks++;
      if ({l_rvalid, l_err} !== {p_own == 2, p_own == 2 && p_err} || l_rdata !== ((p_own == 2) ? p_data : 32'h0)) begin
        errors++; $display("FAIL rnd_lrsp[%0d]: got v/e=%b data=%h want %b %h", cyc, {l_rvalid, l_err}, l_rdata,
                           {p_own == 2, p_own == 2 && p_err}, (p_own == 2) ? p_data : 32'h0);
      end
      f_done = e_fg; l_done = e_lg;
      advance();
    end
    if (f_done) f_req = 1'b0;
    if (l_done) l_req = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_loader_write();
    test_starve();
    test_errors();
    test_reset_pending();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1);
  end

endmodule
